// File: rtl/vector_sched_pkg.sv
// rtl/vector_sched_pkg.sv - shared state encoding and width helpers for the vector test scheduler
package vector_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RES,
        NEXT,
        DONE
    } sched_state_t;

    localparam int DEF_N_VECTORS      = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Bits needed to hold a vector index 0..n-1
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold a tally 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to hold a timer value 0..t-1
    function automatic int timer_width(input int t);
        return (t < 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/verdict_timer.sv
// rtl/verdict_timer.sv - per-vector verdict wait counter with expiry flag at TIMEOUT_CYCLES-1
module verdict_timer
    import vector_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int TW            = timer_width(TIMEOUT_CYCLES)
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [TW-1:0] count;

    assign o_expired = (count == TW'(TIMEOUT_CYCLES - 1));

    // Count enabled cycles; hold at the expiry value so the counter never wraps
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable && !o_expired) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/vector_test_scheduler.sv
// rtl/vector_test_scheduler.sv - issues vectors, collects verdicts with timeout, tallies results; STOP_ON_FAIL_EN ends the run at the first fail
module vector_test_scheduler
    import vector_sched_pkg::*;
#(
    parameter int N_VECTORS      = DEF_N_VECTORS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W         = idx_width(N_VECTORS),
    localparam int CNT_W         = cnt_width(N_VECTORS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    output logic             o_vec_valid,
    output logic [IDX_W-1:0] o_vec_idx,
    input  logic             i_vec_ready,
    input  logic             i_chk_done,
    input  logic             i_chk_pass,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic             o_timeout,
    output logic [IDX_W-1:0] o_first_fail_idx,
    output logic             o_all_pass
);

    sched_state_t     state;
    sched_state_t     state_next;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             timeout_flag;
    logic [IDX_W-1:0] first_fail;
    logic             expired;
    logic             run_start;
    logic             verdict;
    logic             tmo_fail;
    logic             any_fail;
    logic             is_last;

    assign is_last  = (idx == IDX_W'(N_VECTORS - 1));
    assign any_fail = (verdict && !i_chk_pass) || tmo_fail;

    // Timer runs only while waiting for a verdict and is zero everywhere else
    verdict_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (state != WAIT_RES),
        .i_enable (state == WAIT_RES),
        .o_expired(expired)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, event decode and state-derived outputs
    always_comb begin
        state_next  = state;
        run_start   = 1'b0;
        verdict     = 1'b0;
        tmo_fail    = 1'b0;
        o_vec_valid = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    run_start  = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                o_vec_valid = 1'b1;
                o_busy      = 1'b1;
                if (i_vec_ready) begin
                    state_next = WAIT_RES;
                end
            end
            WAIT_RES: begin
                o_busy = 1'b1;
                // A verdict arriving on the expiry cycle takes priority over the timeout
                if (i_chk_done) begin
                    verdict = 1'b1;
                end else if (expired) begin
                    tmo_fail = 1'b1;
                end
                if (verdict || tmo_fail) begin
                    state_next = NEXT;
`ifdef STOP_ON_FAIL_EN
                    if ((verdict && !i_chk_pass) || tmo_fail) begin
                        state_next = DONE;
                    end
`endif
                end
            end
            NEXT: begin
                o_busy     = 1'b1;
                state_next = is_last ? DONE : ISSUE;
            end
            DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    run_start  = 1'b1;
                    state_next = ISSUE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Index, tallies, sticky timeout and first-fail capture; all cleared on an accepted start
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idx          <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            timeout_flag <= 1'b0;
            first_fail   <= '0;
        end else if (run_start) begin
            idx          <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            timeout_flag <= 1'b0;
            first_fail   <= '0;
        end else begin
            if (state == NEXT && !is_last) begin
                idx <= idx + IDX_W'(1);
            end
            if (verdict && i_chk_pass) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
            if (any_fail) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
                if (fail_cnt == '0) begin
                    first_fail <= idx;
                end
            end
            if (tmo_fail) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign o_vec_idx        = idx;
    assign o_pass_cnt       = pass_cnt;
    assign o_fail_cnt       = fail_cnt;
    assign o_timeout        = timeout_flag;
    assign o_first_fail_idx = first_fail;
    assign o_all_pass       = o_done && (fail_cnt == '0);

endmodule

// File: tb/tb_vector_test_scheduler.sv
// tb/tb_vector_test_scheduler.sv - directed self-checking bench for vector_test_scheduler (N=4, timeout 8)
module tb_vector_test_scheduler;

    logic       i_clk;
    logic       i_reset;
    logic       i_start;
    logic       o_vec_valid;
    logic [1:0] o_vec_idx;
    logic       i_vec_ready;
    logic       i_chk_done;
    logic       i_chk_pass;
    logic       o_busy;
    logic       o_done;
    logic [2:0] o_pass_cnt;
    logic [2:0] o_fail_cnt;
    logic       o_timeout;
    logic [1:0] o_first_fail_idx;
    logic       o_all_pass;

    int n_checks = 0;
    int n_passed = 0;

    vector_test_scheduler #(
        .N_VECTORS     (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .o_vec_valid     (o_vec_valid),
        .o_vec_idx       (o_vec_idx),
        .i_vec_ready     (i_vec_ready),
        .i_chk_done      (i_chk_done),
        .i_chk_pass      (i_chk_pass),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_pass_cnt      (o_pass_cnt),
        .o_fail_cnt      (o_fail_cnt),
        .o_timeout       (o_timeout),
        .o_first_fail_idx(o_first_fail_idx),
        .o_all_pass      (o_all_pass)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_run();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Called in ISSUE with i_vec_ready=1; w extra WAIT_RES cycles precede the verdict cycle
    task automatic run_vec(input int exp_idx, input int w, input bit give, input bit pass);
        check("vec_valid", 32'(o_vec_valid), 1);
        check("vec_idx", 32'(o_vec_idx), exp_idx);
        tick();
        repeat (w) tick();
        if (give) begin
            i_chk_done = 1'b1;
            i_chk_pass = pass;
            tick();
            i_chk_done = 1'b0;
            i_chk_pass = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(o_vec_valid), 0);
        check({tag, "_idx"}, 32'(o_vec_idx), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_pass"}, 32'(o_pass_cnt), 0);
        check({tag, "_fail"}, 32'(o_fail_cnt), 0);
        check({tag, "_tmo"}, 32'(o_timeout), 0);
        check({tag, "_ffi"}, 32'(o_first_fail_idx), 0);
        check({tag, "_allpass"}, 32'(o_all_pass), 0);
    endtask

    initial begin
        i_reset     = 1'b0;
        i_start     = 1'b0;
        i_vec_ready = 1'b0;
        i_chk_done  = 1'b0;
        i_chk_pass  = 1'b0;
        #2 i_reset  = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        i_reset = 1'b0;
        tick();

        // Run A: all pass, verdict 2 cycles after accept
        i_vec_ready = 1'b1;
        start_run();
        for (int i = 0; i < 4; i++) begin
            run_vec(i, 1, 1'b1, 1'b1);
            if (i == 0) check("a_next_busy", 32'(o_busy), 1);
            tick();
        end
        check("a_done", 32'(o_done), 1);
        check("a_busy", 32'(o_busy), 0);
        check("a_pass", 32'(o_pass_cnt), 4);
        check("a_fail", 32'(o_fail_cnt), 0);
        check("a_allpass", 32'(o_all_pass), 1);
        check("a_tmo", 32'(o_timeout), 0);

        // Run B: restart from DONE, backpressure, stray verdicts, start while busy, vector 2 fails
        i_vec_ready = 1'b0;
        start_run();
        check("b_done_clr", 32'(o_done), 0);
        check("b_pass_clr", 32'(o_pass_cnt), 0);
        i_chk_done = 1'b1;
        i_chk_pass = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(o_vec_valid), 1);
            check("bp_idx", 32'(o_vec_idx), 0);
            check("bp_timer", 32'(dut.u_timer.count), 0);
            tick();
            i_chk_done = 1'b0;
            i_chk_pass = 1'b0;
        end
        check("b_stray_pass", 32'(o_pass_cnt), 0);
        check("b_stray_fail", 32'(o_fail_cnt), 0);
        i_vec_ready = 1'b1;
        run_vec(0, 1, 1'b1, 1'b1);
        tick();
        i_start = 1'b1;
        run_vec(1, 1, 1'b1, 1'b1);
        i_start = 1'b0;
        tick();
        run_vec(2, 1, 1'b1, 1'b0);
        check("b_ffi", 32'(o_first_fail_idx), 2);
`ifdef STOP_ON_FAIL_EN
        check("b_done", 32'(o_done), 1);
        check("b_pass", 32'(o_pass_cnt), 2);
`else
        tick();
        run_vec(3, 1, 1'b1, 1'b1);
        tick();
        check("b_done", 32'(o_done), 1);
        check("b_pass", 32'(o_pass_cnt), 3);
`endif
        check("b_fail", 32'(o_fail_cnt), 1);
        check("b_allpass", 32'(o_all_pass), 0);
        check("b_tmo", 32'(o_timeout), 0);

        // Run C: vector 1 never gets a verdict
        start_run();
        check("c_ffi_clr", 32'(o_first_fail_idx), 0);
        run_vec(0, 1, 1'b1, 1'b1);
        tick();
        run_vec(1, 7, 1'b0, 1'b0);
        check("c_pre_fail", 32'(o_fail_cnt), 0);
        check("c_pre_tmo", 32'(o_timeout), 0);
        check("c_pre_busy", 32'(o_busy), 1);
        tick();
        check("c_fail", 32'(o_fail_cnt), 1);
        check("c_tmo", 32'(o_timeout), 1);
        check("c_ffi", 32'(o_first_fail_idx), 1);
`ifdef STOP_ON_FAIL_EN
        check("c_done", 32'(o_done), 1);
        check("c_pass", 32'(o_pass_cnt), 1);
`else
        tick();
        run_vec(2, 1, 1'b1, 1'b1);
        tick();
        run_vec(3, 1, 1'b1, 1'b1);
        tick();
        check("c_done", 32'(o_done), 1);
        check("c_pass", 32'(o_pass_cnt), 3);
        check("c_tmo_sticky", 32'(o_timeout), 1);
`endif
        check("c_allpass", 32'(o_all_pass), 0);

        // Run D: verdicts landing on the final timer cycle count as verdicts
        start_run();
        check("d_tmo_clr", 32'(o_timeout), 0);
        run_vec(0, 7, 1'b1, 1'b1);
        check("d0_pass", 32'(o_pass_cnt), 1);
        check("d0_fail", 32'(o_fail_cnt), 0);
        check("d0_tmo", 32'(o_timeout), 0);
        tick();
        run_vec(1, 7, 1'b1, 1'b0);
        check("d1_fail", 32'(o_fail_cnt), 1);
        check("d1_tmo", 32'(o_timeout), 0);
        check("d1_ffi", 32'(o_first_fail_idx), 1);
`ifdef STOP_ON_FAIL_EN
        check("d_done", 32'(o_done), 1);
`else
        tick();
        run_vec(2, 1, 1'b1, 1'b1);
        tick();
        run_vec(3, 1, 1'b1, 1'b1);
        tick();
        check("d_done", 32'(o_done), 1);
        check("d_pass", 32'(o_pass_cnt), 3);
        check("d_tmo", 32'(o_timeout), 0);
`endif

        // Run E: asynchronous reset in WAIT_RES, then a clean run
        start_run();
        run_vec(0, 1, 1'b1, 1'b1);
        tick();
        check("e_idx1", 32'(o_vec_idx), 1);
        tick();
        tick();
        check("e_pre_busy", 32'(o_busy), 1);
        i_reset = 1'b1;
        #1;
        check_idle_outputs("arst");
        tick();
        i_reset = 1'b0;
        tick();
        check("e_idle_busy", 32'(o_busy), 0);
        start_run();
        for (int i = 0; i < 4; i++) begin
            run_vec(i, 1, 1'b1, 1'b1);
            tick();
        end
        check("e_done", 32'(o_done), 1);
        check("e_pass", 32'(o_pass_cnt), 4);
        check("e_allpass", 32'(o_all_pass), 1);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
